// File: rtl/sort_pkg.sv
// ---------------------------------------------------------------------------
// sort_pkg
//   Shared definitions for the in-place RAM sorter and its top level.
//   - DEF_ADDR_WIDTH / DEF_DATA_WIDTH : default RAM geometry, also used by
//     the sort_top wrapper that owns the RAM and the load/readout mux.
//   - sort_state_t : sequencer state encoding, exported on dbg_state so
//     checkers can bind to the FSM without reaching into the hierarchy.
// ---------------------------------------------------------------------------
package sort_pkg;

    localparam int DEF_ADDR_WIDTH = 2;
    localparam int DEF_DATA_WIDTH = 8;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD_A = 3'd1,
        ST_RD_B = 3'd2,
        ST_CMP  = 3'd3,
        ST_WR_A = 3'd4,
        ST_WR_B = 3'd5,
        ST_DONE = 3'd6
    } sort_state_t;

endpackage : sort_pkg

// File: rtl/bubble_sort_ctrl.sv
// ---------------------------------------------------------------------------
// bubble_sort_ctrl
//   Bubble-sort sequencer that sorts a single-port RAM in place, ascending,
//   comparing elements as unsigned numbers.  It drives the RAM's we/addr/din
//   directly and consumes dout, which returns mem[addr] one cycle after the
//   address is presented.  The parent muxes the RAM between its loader and
//   this block; this block owns the RAM whenever busy=1.
//
// Ports
//   clk        : clock, all state changes on posedge
//   rst        : synchronous active-high reset (aborts a sort on that edge)
//   start      : begin a sort; looked at only in IDLE
//   busy       : high in every state except IDLE
//   done       : one-cycle pulse, coincident with the DONE state
//   ram_we     : RAM write enable, only ever high in WR_A / WR_B
//   ram_addr   : RAM address
//   ram_din    : RAM write data
//   ram_dout   : RAM read data (mem[address of previous cycle])
//   dbg_state  : current sequencer state, for debug and checkers
//
// Handshake
//   start is a level sampled in IDLE only; a start seen while busy is ignored.
//   done pulses once per completed sort; if start is still high in the IDLE
//   cycle after done, a new sort begins.
//
// Timing
//   A compare costs 3 cycles (RD_A, RD_B, CMP) and 5 with a swap (+WR_A, WR_B).
//   Every RAM-facing output is registered: each transition loads the output
//   values belonging to the state being entered.
// ---------------------------------------------------------------------------
module bubble_sort_ctrl
    import sort_pkg::*;
#(
    parameter int addr_width = DEF_ADDR_WIDTH,
    parameter int data_width = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  ram_we,
    output logic [addr_width-1:0] ram_addr,
    output logic [data_width-1:0] ram_din,
    input  logic [data_width-1:0] ram_dout,
    output sort_state_t           dbg_state
);

    // The pass bound is computed one bit wider than an address so that
    // N-2-pass can never wrap, whatever addr_width is.
    localparam int AW1 = addr_width + 1;
    localparam logic [addr_width:0] N_M2 = AW1'((2 ** addr_width) - 2);

    sort_state_t           state;
    logic [addr_width-1:0] idx;      // position of the left element of the pair
    logic [addr_width-1:0] pass;     // current pass number, 0 .. N-2
    logic                  swapped;  // a swap happened in the current pass
    logic [data_width-1:0] reg_a;    // mem[idx] captured in RD_B

    // Combinational helpers for the advance decision.
    logic [addr_width-1:0] idx_inc;
    logic [addr_width:0]   bound;
    logic                  more_in_pass;
    logic                  last_pass;
    logic                  need_swap;
    logic                  swapped_eff;
    logic                  do_adv;

    always_comb begin
        idx_inc      = idx + addr_width'(1);
        bound        = N_M2 - {1'b0, pass};
        more_in_pass = ({1'b0, idx} < bound);
        last_pass    = (pass == N_M2[addr_width-1:0]);
        // In CMP, ram_dout is mem[idx+1]; strict compare keeps equal
        // elements in place (stable, and no redundant writes).
        need_swap    = (reg_a > ram_dout);
        // WR_B is the cycle that records the swap, and its own advance
        // decision must already see it.
        swapped_eff  = swapped || (state == ST_WR_B);
        // Advance happens after a non-swapping compare or after the second
        // write of a swap.
        do_adv       = ((state == ST_CMP) && !need_swap) || (state == ST_WR_B);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            ram_we   <= 1'b0;
            ram_addr <= '0;
            ram_din  <= '0;
            idx      <= '0;
            pass     <= '0;
            swapped  <= 1'b0;
            reg_a    <= '0;
        end else begin
            done <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        idx      <= '0;
                        pass     <= '0;
                        swapped  <= 1'b0;
                        state    <= ST_RD_A;
                        busy     <= 1'b1;
                        ram_we   <= 1'b0;
                        ram_addr <= '0;
                    end
                end

                ST_RD_A: begin
                    // Address idx is on the bus now; present idx+1 next.
                    state    <= ST_RD_B;
                    ram_addr <= idx_inc;
                end

                ST_RD_B: begin
                    // ram_dout is mem[idx] this cycle.
                    reg_a <= ram_dout;
                    state <= ST_CMP;
                end

                ST_CMP: begin
                    if (need_swap) begin
                        // The smaller right-hand value goes to idx first;
                        // ram_din itself serves as the holding register.
                        state    <= ST_WR_A;
                        ram_we   <= 1'b1;
                        ram_addr <= idx;
                        ram_din  <= ram_dout;
                    end
                end

                ST_WR_A: begin
                    state    <= ST_WR_B;
                    ram_addr <= idx_inc;
                    ram_din  <= reg_a;
                end

                ST_WR_B: begin
                    swapped <= 1'b1;
                end

                ST_DONE: begin
                    state    <= ST_IDLE;
                    busy     <= 1'b0;
                    ram_we   <= 1'b0;
                    ram_addr <= '0;
                    ram_din  <= '0;
                end

                default: begin
                    state    <= ST_IDLE;
                    busy     <= 1'b0;
                    ram_we   <= 1'b0;
                    ram_addr <= '0;
                    ram_din  <= '0;
                end
            endcase

            // Advance to the next pair, the next pass, or finish.  Placed
            // after the case so these assignments take precedence.
            if (do_adv) begin
                ram_we <= 1'b0;
                if (more_in_pass) begin
                    idx      <= idx_inc;
                    state    <= ST_RD_A;
                    ram_addr <= idx_inc;
                end else if (!swapped_eff || last_pass) begin
                    state    <= ST_DONE;
                    done     <= 1'b1;
                    ram_addr <= '0;
                    ram_din  <= '0;
                end else begin
                    pass     <= pass + addr_width'(1);
                    idx      <= '0;
                    swapped  <= 1'b0;
                    state    <= ST_RD_A;
                    ram_addr <= '0;
                end
            end
        end
    end

    assign dbg_state = state;

endmodule : bubble_sort_ctrl

// File: tb/tb_bubble_sort_ctrl.sv
// ---------------------------------------------------------------------------
// tb_bubble_sort_ctrl
//   Two controllers: unit A with addr_width=2 (directed cases) and unit B
//   with addr_width=3 (random data).  Each has a behavioural RAM and a
//   loader mux selected by busy, as the real parent would have.
// ---------------------------------------------------------------------------
module tb_bubble_sort_ctrl;
    import sort_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // ---------------- unit A (N=4) ----------------
    logic        a_start = 1'b0;
    logic        a_busy, a_done, a_we;
    logic [1:0]  a_addr;
    logic [7:0]  a_din, a_dout;
    sort_state_t a_state;
    logic        a_ld_we = 1'b0;
    logic [1:0]  a_ld_addr = '0;
    logic [7:0]  a_ld_din = '0;
    logic [7:0]  mem_a [4];

    bubble_sort_ctrl #(.addr_width(2), .data_width(8)) dut_a (
        .clk(clk), .rst(rst), .start(a_start), .busy(a_busy), .done(a_done),
        .ram_we(a_we), .ram_addr(a_addr), .ram_din(a_din), .ram_dout(a_dout),
        .dbg_state(a_state)
    );

    always @(posedge clk) begin
        if (a_busy) begin
            if (a_we) mem_a[a_addr] <= a_din;
            a_dout <= mem_a[a_addr];
        end else begin
            if (a_ld_we) mem_a[a_ld_addr] <= a_ld_din;
            a_dout <= mem_a[a_ld_addr];
        end
    end

    // ---------------- unit B (N=8) ----------------
    logic        b_start = 1'b0;
    logic        b_busy, b_done, b_we;
    logic [2:0]  b_addr;
    logic [7:0]  b_din, b_dout;
    sort_state_t b_state;
    logic        b_ld_we = 1'b0;
    logic [2:0]  b_ld_addr = '0;
    logic [7:0]  b_ld_din = '0;
    logic [7:0]  mem_b [8];

    bubble_sort_ctrl #(.addr_width(3), .data_width(8)) dut_b (
        .clk(clk), .rst(rst), .start(b_start), .busy(b_busy), .done(b_done),
        .ram_we(b_we), .ram_addr(b_addr), .ram_din(b_din), .ram_dout(b_dout),
        .dbg_state(b_state)
    );

    always @(posedge clk) begin
        if (b_busy) begin
            if (b_we) mem_b[b_addr] <= b_din;
            b_dout <= mem_b[b_addr];
        end else begin
            if (b_ld_we) mem_b[b_ld_addr] <= b_ld_din;
            b_dout <= mem_b[b_ld_addr];
        end
    end

    // ---------------- activity monitors (away from active edge) --------
    logic clr_mon = 1'b0;
    int a_scan = 0, a_wr = 0, a_dn = 0;
    int b_scan = 0, b_wr = 0, b_dn = 0;

    always @(negedge clk) begin
        if (clr_mon) begin
            a_scan = 0; a_wr = 0; a_dn = 0;
            b_scan = 0; b_wr = 0; b_dn = 0;
        end else begin
            if (a_busy && !a_done) a_scan++;
            if (a_we) a_wr++;
            if (a_done) a_dn++;
            if (b_busy && !b_done) b_scan++;
            if (b_we) b_wr++;
            if (b_done) b_dn++;
        end
    end

    // ---------------- scoreboard helpers ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: plain bubble sort with early exit, counting swaps and the
    // cycle cost (3 per compare, 2 more per swap).
    function automatic void model(input int n, inout int a[8], output int swaps, output int cyc);
        int t;
        bit sw;
        swaps = 0;
        cyc   = 0;
        for (int p = 0; p <= n - 2; p++) begin
            sw = 0;
            for (int i = 0; i <= n - 2 - p; i++) begin
                cyc += 3;
                if (a[i] > a[i+1]) begin
                    t = a[i]; a[i] = a[i+1]; a[i+1] = t;
                    cyc += 2;
                    swaps++;
                    sw = 1;
                end
            end
            if (!sw) break;
        end
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        clr_mon = 1'b1;
        step();
        clr_mon = 1'b0;
    endtask

    // ---------------- driver tasks, unit A ----------------
    task automatic load_a(input int v[4]);
        for (int i = 0; i < 4; i++) begin
            a_ld_we = 1'b1; a_ld_addr = 2'(i); a_ld_din = 8'(v[i]);
            step();
        end
        a_ld_we = 1'b0;
    endtask

    task automatic wait_done_a(input string tag, input int n_done);
        int budget = 400;
        while (a_dn < n_done && budget > 0) begin
            step();
            budget--;
        end
        check({tag, "_timeout"}, 32'(a_dn >= n_done), 32'd1);
    endtask

    // Sort v on unit A; optionally pulse start again while busy.
    task automatic run_a(input string tag, input int v[4], input bit poke_busy);
        int m[8];
        int exp_q[$];
        int swaps, cyc;
        for (int i = 0; i < 8; i++) m[i] = (i < 4) ? v[i] : 0;
        model(4, m, swaps, cyc);
        for (int i = 0; i < 4; i++) exp_q.push_back(m[i]);

        load_a(v);
        clear_mon();
        a_start = 1'b1;
        step();
        a_start = 1'b0;
        if (poke_busy) begin
            step(); step();
            a_start = 1'b1;
            step();
            a_start = 1'b0;
        end
        wait_done_a(tag, 1);
        step(); step(); step();
        check({tag, "_done_pulses"}, 32'(a_dn), 32'd1);
        check({tag, "_busy_idle"}, 32'(a_busy), 32'd0);
        check({tag, "_scan_cycles"}, 32'(a_scan), 32'(cyc));
        check({tag, "_write_cycles"}, 32'(a_wr), 32'(2 * swaps));
        for (int i = 0; i < 4; i++) begin
            a_ld_addr = 2'(i);
            step();
            check($sformatf("%s_rd%0d", tag, i), 32'(a_dout), 32'(exp_q.pop_front()));
        end
    endtask

    // ---------------- driver tasks, unit B ----------------
    task automatic run_b(input int seed_idx);
        int v[8];
        int m[8];
        int exp_q[$];
        int swaps, cyc, budget;
        for (int i = 0; i < 8; i++) begin
            v[i] = int'($urandom_range(0, 255));
            m[i] = v[i];
        end
        model(8, m, swaps, cyc);
        for (int i = 0; i < 8; i++) exp_q.push_back(m[i]);

        for (int i = 0; i < 8; i++) begin
            b_ld_we = 1'b1; b_ld_addr = 3'(i); b_ld_din = 8'(v[i]);
            step();
        end
        b_ld_we = 1'b0;
        clear_mon();
        b_start = 1'b1;
        step();
        b_start = 1'b0;
        budget = 400;
        while (b_dn < 1 && budget > 0) begin
            step();
            budget--;
        end
        step(); step();
        check($sformatf("rnd%0d_done_pulses", seed_idx), 32'(b_dn), 32'd1);
        check($sformatf("rnd%0d_scan_cycles", seed_idx), 32'(b_scan), 32'(cyc));
        for (int i = 0; i < 8; i++) begin
            b_ld_addr = 3'(i);
            step();
            check($sformatf("rnd%0d_rd%0d", seed_idx, i), 32'(b_dout), 32'(exp_q.pop_front()));
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int budget;

        // Reset state
        rst = 1'b1;
        step(); step(); step();
        check("rst_busy", 32'(a_busy), 32'd0);
        check("rst_done", 32'(a_done), 32'd0);
        check("rst_we", 32'(a_we), 32'd0);
        check("rst_addr", 32'(a_addr), 32'd0);
        check("rst_din", 32'(a_din), 32'd0);
        check("rst_state", 32'(a_state), 32'(ST_IDLE));
        check("rst_b_busy", 32'(b_busy), 32'd0);
        rst = 1'b0;
        step();

        // Directed data patterns
        run_a("rev", '{4, 3, 2, 1}, 1'b0);
        check("rev_scan_const", 32'(a_scan), 32'd30);
        run_a("sorted", '{1, 2, 3, 4}, 1'b0);
        check("sorted_no_writes", 32'(a_wr), 32'd0);
        check("sorted_scan_const", 32'(a_scan), 32'd9);
        run_a("equal", '{7, 7, 0, 7}, 1'b0);
        run_a("msb", '{255, 0, 128, 1}, 1'b0);
        run_a("busy_start", '{9, 200, 3, 3}, 1'b1);

        // Reset in the cycle after WR_A
        load_a('{4, 3, 2, 1});
        a_start = 1'b1;
        step();
        a_start = 1'b0;
        budget = 100;
        while (a_state != ST_WR_A && budget > 0) begin
            step();
            budget--;
        end
        check("midrst_reach_wr_a", 32'(a_state == ST_WR_A), 32'd1);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_busy", 32'(a_busy), 32'd0);
        check("midrst_we", 32'(a_we), 32'd0);
        check("midrst_state", 32'(a_state), 32'(ST_IDLE));
        step();
        check("midrst_we_after", 32'(a_we), 32'd0);
        run_a("after_rst", '{2, 4, 1, 3}, 1'b0);

        // start held across DONE launches a second sort
        load_a('{1, 2, 3, 4});
        clear_mon();
        a_start = 1'b1;
        wait_done_a("held", 2);
        a_start = 1'b0;
        budget = 100;
        while (a_busy && budget > 0) begin
            step();
            budget--;
        end
        check("held_done_pulses", 32'(a_dn), 32'd2);
        check("held_idle", 32'(a_busy), 32'd0);

        // Random data on the 8-entry unit
        for (int s = 0; s < 100; s++) run_b(s);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_bubble_sort_ctrl
